// File: rtl/ps2_key_event_ctrl_if.sv
// Keyboard-port bus between the PS/2 event controller and its consumer.
// master drives received bytes and pop/clear requests; slave returns the head event and status.
interface ps2_key_event_ctrl_if #(
  parameter int AW = 3
);
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        rx_error;
  logic        rd_en;
  logic        clr_status;
  logic [7:0]  key_code;
  logic        key_ext;
  logic        key_brk;
  logic        key_valid;
  logic [AW:0] fifo_count;
  logic        overflow;
  logic        frame_err;
  logic        irq;

  modport master (
    output rx_byte, rx_valid, rx_error, rd_en, clr_status,
    input  key_code, key_ext, key_brk, key_valid, fifo_count, overflow, frame_err, irq
  );

  modport slave (
    input  rx_byte, rx_valid, rx_error, rd_en, clr_status,
    output key_code, key_ext, key_brk, key_valid, fifo_count, overflow, frame_err, irq
  );
endinterface

// File: rtl/ps2_key_event_ctrl.sv
// PS/2 set-2 prefix sequencer feeding a show-ahead key-event FIFO with
// pop handshake, level irq and sticky overflow / frame-error status.
module ps2_key_event_ctrl #(
  parameter int DEPTH       = 8,
  parameter int AW          = $clog2(DEPTH),
  parameter int TIMEOUT_CYC = 100000,
  parameter int PAUSE_LEN   = 7
) (
  input logic                 clk,
  input logic                 rst_n,
  ps2_key_event_ctrl_if.slave bus
);
  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } key_ev_t;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_EXT     = 3'd1;
  localparam logic [2:0] S_BRK     = 3'd2;
  localparam logic [2:0] S_EXT_BRK = 3'd3;
  localparam logic [2:0] S_PAUSE   = 3'd4;

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int PW = $clog2(PAUSE_LEN + 1);

  logic [2:0]    state, state_nx;
  logic [PW-1:0] pcnt, pcnt_nx;
  logic [TW-1:0] tcnt;
  logic          tmo, ev_push;
  key_ev_t       ev;

  key_ev_t       mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          empty, full, pop, push_ok, ovf_set, ferr_set;
  logic          overflow, frame_err, irq;
  key_ev_t       head;

  // Sequencer: rx_error beats rx_valid, and a byte arriving on the timeout cycle beats the timeout.
  always_comb begin
    state_nx = state;
    pcnt_nx  = pcnt;
    ev_push  = 1'b0;
    ev       = '0;
    ev.code  = bus.rx_byte;
    tmo      = (state != S_IDLE) && !bus.rx_valid && !bus.rx_error &&
               (tcnt == TW'(TIMEOUT_CYC - 1));
    if (bus.rx_error || tmo) begin
      state_nx = S_IDLE;
    end else if (bus.rx_valid) begin
      case (state)
        S_IDLE: begin
          case (bus.rx_byte)
            8'hE0: state_nx = S_EXT;
            8'hF0: state_nx = S_BRK;
            8'hE1: begin
              state_nx = S_PAUSE;
              pcnt_nx  = PW'(PAUSE_LEN);
            end
            8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hFF: ev_push = 1'b0;
            default: ev_push = 1'b1;
          endcase
        end
        S_EXT: begin
          if (bus.rx_byte == 8'hF0) begin
            state_nx = S_EXT_BRK;
          end else begin
            state_nx = S_IDLE;
            ev.ext   = 1'b1;
            ev_push  = (bus.rx_byte != 8'h12);
          end
        end
        S_BRK: begin
          state_nx = S_IDLE;
          ev.brk   = 1'b1;
          ev_push  = 1'b1;
        end
        S_EXT_BRK: begin
          state_nx = S_IDLE;
          ev.ext   = 1'b1;
          ev.brk   = 1'b1;
          ev_push  = (bus.rx_byte != 8'h12);
        end
        S_PAUSE: begin
          pcnt_nx = pcnt - PW'(1);
          if (pcnt == PW'(1)) begin
            state_nx = S_IDLE;
            ev.code  = 8'hE1;
            ev_push  = 1'b1;
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      pcnt  <= '0;
      tcnt  <= '0;
    end else begin
      state <= state_nx;
      pcnt  <= pcnt_nx;
      if (bus.rx_valid || bus.rx_error || state == S_IDLE || tmo) tcnt <= '0;
      else                                                        tcnt <= tcnt + TW'(1);
    end
  end

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign pop      = bus.rd_en && !empty;
  assign push_ok  = ev_push && (!full || pop);
  assign ovf_set  = ev_push && full && !pop;
  assign ferr_set = bus.rx_error || tmo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= ev;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push_ok && !pop)      count <= count + (AW+1)'(1);
      else if (pop && !push_ok) count <= count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      frame_err <= 1'b0;
      irq       <= 1'b0;
    end else begin
      if (ovf_set)             overflow  <= 1'b1;
      else if (bus.clr_status) overflow  <= 1'b0;
      if (ferr_set)            frame_err <= 1'b1;
      else if (bus.clr_status) frame_err <= 1'b0;
      irq <= !empty;
    end
  end

  // When empty, the slot behind rd_ptr still holds the entry popped last.
  assign head           = empty ? mem[rd_ptr - AW'(1)] : mem[rd_ptr];
  assign bus.key_code   = head.code;
  assign bus.key_ext    = head.ext;
  assign bus.key_brk    = head.brk;
  assign bus.key_valid  = !empty;
  assign bus.fifo_count = count;
  assign bus.overflow   = overflow;
  assign bus.frame_err  = frame_err;
  assign bus.irq        = irq;
endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// Randomized + directed bench for ps2_key_event_ctrl against a queue-based event model.
module tb_ps2_key_event_ctrl;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int TMO   = 64;
  localparam int PLEN  = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ps2_key_event_ctrl_if #(.AW(AW)) bus ();

  ps2_key_event_ctrl #(
    .DEPTH(DEPTH), .AW(AW), .TIMEOUT_CYC(TMO), .PAUSE_LEN(PLEN)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: pending prefixes as flags, FIFO as a queue of {ext,brk,code}.
  logic [9:0] q[$];
  logic [9:0] m_last;
  bit  m_ext, m_brk, m_ovf, m_ferr, m_irq;
  int  m_pause, cyc, last_cyc;
  bit  m_push, m_pop, m_sferr;
  logic [9:0] m_ent;

  function automatic bit busy();
    return m_ext || m_brk || (m_pause > 0);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_last = '0; m_ext = 0; m_brk = 0; m_pause = 0;
      m_ovf = 0; m_ferr = 0; m_irq = 0; cyc = 0; last_cyc = 0;
    end else begin
      m_push = 0; m_sferr = 0; m_ent = '0;
      m_pop = bus.rd_en && (q.size() != 0);
      if (bus.rx_error) begin
        m_ext = 0; m_brk = 0; m_pause = 0; m_sferr = 1;
      end else if (bus.rx_valid) begin
        last_cyc = cyc;
        if (m_pause > 0) begin
          m_pause--;
          if (m_pause == 0) begin m_push = 1; m_ent = 10'h0E1; end
        end else if (m_brk) begin
          m_push = !(m_ext && bus.rx_byte == 8'h12);
          m_ent = {m_ext, 1'b1, bus.rx_byte};
          m_ext = 0; m_brk = 0;
        end else if (m_ext) begin
          if (bus.rx_byte == 8'hF0) m_brk = 1;
          else begin
            m_push = (bus.rx_byte != 8'h12);
            m_ent = {2'b10, bus.rx_byte};
            m_ext = 0;
          end
        end else begin
          case (bus.rx_byte)
            8'hE0: m_ext = 1;
            8'hF0: m_brk = 1;
            8'hE1: m_pause = PLEN;
            8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hFF: m_push = 0;
            default: begin m_push = 1; m_ent = {2'b00, bus.rx_byte}; end
          endcase
        end
      end else if (busy() && (cyc - last_cyc == TMO)) begin
        m_ext = 0; m_brk = 0; m_pause = 0; m_sferr = 1;
      end
      m_irq = (q.size() != 0);
      if (m_push && q.size() == DEPTH && !m_pop) begin
        m_push = 0;
        m_ovf = 1;
      end else if (bus.clr_status) m_ovf = 0;
      if (m_sferr) m_ferr = 1;
      else if (bus.clr_status) m_ferr = 0;
      if (m_pop) m_last = q.pop_front();
      if (m_push) q.push_back(m_ent);
      cyc++;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("key_valid", int'(bus.key_valid), int'(q.size() != 0));
      chk("key_event", int'({bus.key_ext, bus.key_brk, bus.key_code}),
          int'(q.size() != 0 ? q[0] : m_last));
      chk("fifo_count", int'(bus.fifo_count), q.size());
      chk("overflow", int'(bus.overflow), int'(m_ovf));
      chk("frame_err", int'(bus.frame_err), int'(m_ferr));
      chk("irq", int'(bus.irq), int'(m_irq));
    end
  end

  // Called at posedge+1; applies inputs for exactly one clock edge.
  task automatic step(input bit v, input bit e, input logic [7:0] b, input bit rd, input bit clr);
    bus.rx_valid = v; bus.rx_error = e; bus.rx_byte = b;
    bus.rd_en = rd; bus.clr_status = clr;
    @(posedge clk); #1;
    bus.rx_valid = 0; bus.rx_error = 0; bus.rx_byte = 8'h00;
    bus.rd_en = 0; bus.clr_status = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 8'h00, 0, 0);
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    step(1, 0, b, 0, 0);
    idle(gap);
  endtask

  task automatic head_is(input string name, input logic [9:0] exp);
    chk(name, int'({bus.key_ext, bus.key_brk, bus.key_code}), int'(exp));
  endtask

  logic [7:0] seq_ext [10] = '{8'hE0, 8'h12, 8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'hE0, 8'hF0, 8'h12};
  logic [7:0] seq_pause [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

  initial begin
    bus.rx_valid = 0; bus.rx_error = 0; bus.rx_byte = 8'h00;
    bus.rd_en = 0; bus.clr_status = 0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_on = 1;
    chk("rst_key_valid", int'(bus.key_valid), 0);
    chk("rst_count", int'(bus.fifo_count), 0);
    chk("rst_irq", int'(bus.irq), 0);
    head_is("rst_key", 10'h000);
    rst_n = 1;
    idle(2);

    // Make then break of 'A'
    send(8'h1C, 0);
    chk("a_valid", int'(bus.key_valid), 1);
    chk("a_irq_lag", int'(bus.irq), 0);
    idle(1);
    chk("a_irq", int'(bus.irq), 1);
    idle(18);
    send(8'hF0, 19);
    send(8'h1C, 1);
    chk("a_count", int'(bus.fifo_count), 2);
    head_is("a_make", 10'h01C);
    step(0, 0, 8'h00, 1, 0);
    head_is("a_break", 10'h11C);
    step(0, 0, 8'h00, 1, 0);
    chk("a_empty", int'(bus.key_valid), 0);
    head_is("a_hold", 10'h11C);
    chk("a_irq_tail", int'(bus.irq), 1);
    idle(1);
    chk("a_irq_off", int'(bus.irq), 0);

    // Extended key with fake shifts
    foreach (seq_ext[i]) send(seq_ext[i], 2);
    chk("ext_count", int'(bus.fifo_count), 2);
    head_is("ext_make", 10'h275);
    step(0, 0, 8'h00, 1, 0);
    head_is("ext_break", 10'h375);
    step(0, 0, 8'h00, 1, 0);

    // Pause sequence then a plain make
    foreach (seq_pause[i]) send(seq_pause[i], 1);
    send(8'h1C, 1);
    chk("pause_count", int'(bus.fifo_count), 2);
    head_is("pause_evt", 10'h0E1);
    step(0, 0, 8'h00, 1, 0);
    head_is("pause_next", 10'h01C);
    step(0, 0, 8'h00, 1, 0);

    // Overflow
    for (int i = 0; i <= DEPTH; i++) send(8'h15 + 8'(i), 0);
    chk("ovf_count", int'(bus.fifo_count), DEPTH);
    chk("ovf_flag", int'(bus.overflow), 1);
    head_is("ovf_head", 10'h015);
    step(1, 0, 8'h2A, 1, 0);
    chk("ovf_pushpop_count", int'(bus.fifo_count), DEPTH);
    head_is("ovf_pushpop_head", 10'h016);
    step(0, 0, 8'h00, 0, 1);
    chk("ovf_clr", int'(bus.overflow), 0);
    repeat (DEPTH) step(0, 0, 8'h00, 1, 0);
    chk("ovf_drained", int'(bus.fifo_count), 0);
    head_is("ovf_hold", 10'h02A);

    // Timeout boundary, then error beating a valid byte
    send(8'hE0, TMO - 1);
    chk("tmo_before", int'(bus.frame_err), 0);
    idle(1);
    chk("tmo_hit", int'(bus.frame_err), 1);
    chk("tmo_nopush", int'(bus.fifo_count), 0);
    send(8'h75, 1);
    head_is("tmo_idle_after", 10'h075);
    step(0, 0, 8'h00, 1, 0);
    send(8'hF0, 1);
    step(1, 1, 8'h1C, 0, 0);
    chk("err_nopush", int'(bus.fifo_count), 0);
    chk("err_ferr", int'(bus.frame_err), 1);
    send(8'h1C, 1);
    head_is("err_idle_after", 10'h01C);
    step(0, 0, 8'h00, 1, 0);

    // Async reset between F0 and 1C
    send(8'h33, 1);
    send(8'hF0, 1);
    #2 rst_n = 0;
    #1;
    chk("arst_valid", int'(bus.key_valid), 0);
    chk("arst_count", int'(bus.fifo_count), 0);
    chk("arst_ferr", int'(bus.frame_err), 0);
    chk("arst_irq", int'(bus.irq), 0);
    head_is("arst_key", 10'h000);
    @(posedge clk); #3 rst_n = 1;
    @(posedge clk); #1;
    send(8'h1C, 1);
    head_is("arst_make", 10'h01C);
    step(0, 0, 8'h00, 1, 0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      bit v, e, rd, clr;
      logic [7:0] b;
      int sel;
      int rdp;
      if (i % 500 == 250) idle(TMO + 6);
      rdp = ((i / 300) % 2 == 0) ? 40 : 8;
      v = ($urandom_range(0, 99) < 30);
      e = ($urandom_range(0, 79) == 0);
      rd = ($urandom_range(0, 99) < rdp);
      clr = ($urandom_range(0, 59) == 0);
      sel = $urandom_range(0, 11);
      case (sel)
        0: b = 8'hE0;
        1: b = 8'hF0;
        2: b = 8'hE1;
        3: b = 8'h12;
        4: b = 8'hAA;
        default: b = 8'($urandom);
      endcase
      step(v, e, b, rd, clr);
    end
    idle(2);

    chk_on = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
